// File: rtl/iomem_copy_master_pkg.sv
// Shared definitions for the iomem copy master: bus widths, write-strobe
// encodings, FSM state type and the per-word address step helper.
package iomem_copy_master_pkg;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned STRB_W     = 4;
    localparam int unsigned WORD_BYTES = 4;

    localparam logic [STRB_W-1:0] WSTRB_RD = 4'h0;
    localparam logic [STRB_W-1:0] WSTRB_WR = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD     = 3'd1,
        ST_RD_GAP = 3'd2,
        ST_WR     = 3'd3,
        ST_WR_GAP = 3'd4
    } state_t;

    // Next word address; fixed addresses serve FIFO/RNG-style responders.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                    input logic              inc);
        return inc ? a + ADDR_W'(WORD_BYTES) : a;
    endfunction

endpackage

// File: rtl/iomem_copy_master_if.sv
// picosoc iomem bus bundle.
//   valid  : request from initiator
//   ready  : 1-cycle acknowledge from responder
//   wstrb  : 4'h0 read, 4'hF write
//   addr   : beat byte address
//   wdata  : write data
//   rdata  : read data, valid while ready=1
interface iomem_copy_master_if;
    import iomem_copy_master_pkg::*;

    logic              valid;
    logic              ready;
    logic [STRB_W-1:0] wstrb;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;

    modport master (output valid, wstrb, addr, wdata, input ready, rdata);
    modport slave  (input valid, wstrb, addr, wdata, output ready, rdata);

endinterface

// File: rtl/iomem_copy_master_watchdog.sv
// Per-beat timeout counter.
//   clk, reset : clock, synchronous active-high reset
//   load       : clears the counter (held while no beat is outstanding)
//   en         : beat outstanding and not yet acknowledged
//   expired_c  : combinational; high in the TIMEOUT-th waiting cycle.
//                TIMEOUT=0 disables the watchdog (never expires).
module iomem_copy_master_watchdog #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic expired_c
);

    localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST =
        CNT_W'((TIMEOUT == 0) ? 32'd0 : TIMEOUT - 32'd1);

    logic [CNT_W-1:0] cnt;

    // Counts waiting cycles of the current beat; 0 in the first valid cycle.
    always_ff @(posedge clk) begin
        if (reset || load) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // en is low when ready arrives, so ready on the expiry cycle wins.
    assign expired_c = (TIMEOUT != 0) && en && (cnt == LAST);

endmodule

// File: rtl/iomem_copy_master.sv
// iomem copy master: copies cfg_count words from cfg_src to cfg_dst using one
// read beat and one write beat per word, each beat followed by one idle cycle.
//   clk, reset        : clock, synchronous active-high reset
//   start, abort      : start pulse (accepted only when idle), stop request
//   cfg_src/dst       : first word-aligned source/destination addresses
//   cfg_src/dst_inc   : 1 = step by 4 per word, 0 = fixed address
//   cfg_count         : words to copy (0 allowed)
//   busy, done        : transfer in progress, 1-cycle completion pulse
//   err_timeout       : sticky beat timeout flag, cleared by next start
//   words_done        : words fully copied since start
//   bus               : iomem initiator port
module iomem_copy_master
    import iomem_copy_master_pkg::*;
#(
    parameter int unsigned COUNT_W = 16,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic [ADDR_W-1:0]   cfg_src,
    input  logic [ADDR_W-1:0]   cfg_dst,
    input  logic                cfg_src_inc,
    input  logic                cfg_dst_inc,
    input  logic [COUNT_W-1:0]  cfg_count,
    output logic                busy,
    output logic                done,
    output logic                err_timeout,
    output logic [COUNT_W-1:0]  words_done,
    iomem_copy_master_if.master bus
);

    state_t               state;
    logic [ADDR_W-1:0]    src;
    logic [ADDR_W-1:0]    dst;
    logic                 src_inc;
    logic                 dst_inc;
    logic [COUNT_W-1:0]   remaining;
    logic                 abort_pend;

    logic                 wd_load_c;
    logic                 wd_en_c;
    logic                 beat_expired_c;

    assign wd_load_c = ~bus.valid;
    assign wd_en_c   = bus.valid & ~bus.ready;

    iomem_copy_master_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk       (clk),
        .reset     (reset),
        .load      (wd_load_c),
        .en        (wd_en_c),
        .expired_c (beat_expired_c)
    );

    // Copy sequencer; all bus and status outputs are registered here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            bus.valid   <= 1'b0;
            bus.wstrb   <= WSTRB_RD;
            bus.addr    <= '0;
            bus.wdata   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err_timeout <= 1'b0;
            words_done  <= '0;
            src         <= '0;
            dst         <= '0;
            src_inc     <= 1'b0;
            dst_inc     <= 1'b0;
            remaining   <= '0;
            abort_pend  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (busy && abort) begin
                abort_pend <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    // done high means the previous transfer is still closing.
                    if (start && !done) begin
                        src         <= cfg_src;
                        dst         <= cfg_dst;
                        src_inc     <= cfg_src_inc;
                        dst_inc     <= cfg_dst_inc;
                        remaining   <= cfg_count;
                        err_timeout <= 1'b0;
                        words_done  <= '0;
                        abort_pend  <= 1'b0;
                        busy        <= 1'b1;
                        if (cfg_count == '0) begin
                            // Empty copy: WR_GAP closes it on the next cycle.
                            state <= ST_WR_GAP;
                        end else begin
                            bus.valid <= 1'b1;
                            bus.wstrb <= WSTRB_RD;
                            bus.addr  <= cfg_src;
                            state     <= ST_RD;
                        end
                    end
                end

                ST_RD: begin
                    if (bus.ready) begin
                        bus.wdata <= bus.rdata;
                        bus.valid <= 1'b0;
                        state     <= ST_RD_GAP;
                    end else if (beat_expired_c) begin
                        bus.valid   <= 1'b0;
                        err_timeout <= 1'b1;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        abort_pend  <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end

                ST_RD_GAP: begin
                    bus.valid <= 1'b1;
                    bus.wstrb <= WSTRB_WR;
                    bus.addr  <= dst;
                    state     <= ST_WR;
                end

                ST_WR: begin
                    if (bus.ready) begin
                        bus.valid  <= 1'b0;
                        words_done <= words_done + COUNT_W'(1);
                        remaining  <= remaining - COUNT_W'(1);
                        src        <= next_addr(src, src_inc);
                        dst        <= next_addr(dst, dst_inc);
                        state      <= ST_WR_GAP;
                    end else if (beat_expired_c) begin
                        bus.valid   <= 1'b0;
                        err_timeout <= 1'b1;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        abort_pend  <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end

                ST_WR_GAP: begin
                    // Word boundary: the only place an abort takes effect.
                    if (remaining == '0 || abort_pend || abort) begin
                        done       <= 1'b1;
                        busy       <= 1'b0;
                        abort_pend <= 1'b0;
                        state      <= ST_IDLE;
                    end else begin
                        bus.valid <= 1'b1;
                        bus.wstrb <= WSTRB_RD;
                        bus.addr  <= src;
                        state     <= ST_RD;
                    end
                end

                default: begin
                    bus.valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iomem_copy_master.sv
// Scoreboard bench for iomem_copy_master: expected bus beats and done events
// are queued at stimulus time and checked by an independent monitor.
module tb_iomem_copy_master;
    import iomem_copy_master_pkg::*;

    localparam int unsigned COUNT_W = 16;
    localparam int unsigned TIMEOUT = 8;
    localparam logic [31:0] GPIO_BASE = 32'h0300_0000;
    localparam logic [31:0] RNG_BASE  = 32'h0300_1000;
    localparam logic [31:0] RNG_V [3] = '{32'h1234_5678, 32'hDEAD_BEEF, 32'h0BAD_F00D};
    localparam logic [31:0] TAB [4]   = '{32'hA5A5_0001, 32'h5A5A_0002,
                                          32'hCAFE_0003, 32'hF00D_0004};

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               start = 1'b0;
    logic               abort = 1'b0;
    logic [31:0]        cfg_src = '0;
    logic [31:0]        cfg_dst = '0;
    logic               cfg_src_inc = 1'b0;
    logic               cfg_dst_inc = 1'b0;
    logic [COUNT_W-1:0] cfg_count = '0;
    logic               busy;
    logic               done;
    logic               err_timeout;
    logic [COUNT_W-1:0] words_done;

    iomem_copy_master_if bus ();

    always #5 clk = ~clk;

    iomem_copy_master #(
        .COUNT_W (COUNT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .cfg_src     (cfg_src),
        .cfg_dst     (cfg_dst),
        .cfg_src_inc (cfg_src_inc),
        .cfg_dst_inc (cfg_dst_inc),
        .cfg_count   (cfg_count),
        .busy        (busy),
        .done        (done),
        .err_timeout (err_timeout),
        .words_done  (words_done),
        .bus         (bus)
    );

    typedef struct {
        bit          is_done;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          chk_data;
        logic [15:0] words;
        bit          err;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
        end
    endfunction

    function automatic void exp_rd(input logic [31:0] a);
        exp_t e;
        e.is_done = 1'b0; e.wstrb = 4'h0; e.addr = a; e.wdata = '0;
        e.chk_data = 1'b0; e.words = '0; e.err = 1'b0;
        exp_q.push_back(e);
    endfunction

    function automatic void exp_wr(input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        e.is_done = 1'b0; e.wstrb = 4'hF; e.addr = a; e.wdata = d;
        e.chk_data = 1'b1; e.words = '0; e.err = 1'b0;
        exp_q.push_back(e);
    endfunction

    function automatic void exp_done(input logic [15:0] w, input bit err);
        exp_t e;
        e.is_done = 1'b1; e.wstrb = 4'h0; e.addr = '0; e.wdata = '0;
        e.chk_data = 1'b0; e.words = w; e.err = err;
        exp_q.push_back(e);
    endfunction

    // Responder: picosoc-style 1-cycle ready, RNG and GPIO plus a small RAM.
    logic        stall = 1'b0;
    logic [31:0] mem [256];
    logic [31:0] gpio_q;
    logic [1:0]  rng_idx = 2'd0;

    always @(posedge clk) begin
        if (reset) begin
            bus.ready <= 1'b0;
            bus.rdata <= '0;
            gpio_q    <= '0;
            for (int i = 0; i < 4; i++) mem[8'(64 + i)] <= TAB[i];
        end else begin
            bus.ready <= 1'b0;
            if (bus.valid && !bus.ready && !stall) begin
                bus.ready <= 1'b1;
                if (bus.wstrb == 4'h0) begin
                    if (bus.addr == RNG_BASE) begin
                        bus.rdata <= RNG_V[rng_idx];
                        rng_idx   <= rng_idx + 2'd1;
                    end else if (bus.addr == GPIO_BASE) begin
                        bus.rdata <= gpio_q;
                    end else begin
                        bus.rdata <= mem[bus.addr[9:2]];
                    end
                end else if (bus.addr == GPIO_BASE) begin
                    gpio_q <= bus.wdata;
                end else begin
                    mem[bus.addr[9:2]] <= bus.wdata;
                end
            end
        end
    end

    // Monitor: scoreboard pops plus bus protocol checks.
    exp_t        mon_e;
    logic        pv = 1'b0;
    logic        pr = 1'b0;
    logic        prst = 1'b1;
    logic [3:0]  pws = '0;
    logic [31:0] pa = '0;
    logic [31:0] pd = '0;

    always @(negedge clk) begin
        if (!reset && !prst) begin
            if (pv && !pr && !err_timeout) begin
                chk("hold_valid", 32'(bus.valid), 32'd1);
                chk("hold_addr",  bus.addr, pa);
                chk("hold_wstrb", 32'(bus.wstrb), 32'(pws));
                chk("hold_wdata", bus.wdata, pd);
            end
            if (pv && pr) chk("gap_after_ready", 32'(bus.valid), 32'd0);
            if (bus.valid && bus.ready) begin
                if (exp_q.size() == 0) begin
                    chk("beat_expected", 32'(exp_q.size()), 32'd1);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("beat_kind",  32'(mon_e.is_done), 32'd0);
                    chk("beat_addr",  bus.addr, mon_e.addr);
                    chk("beat_wstrb", 32'(bus.wstrb), 32'(mon_e.wstrb));
                    if (mon_e.chk_data) chk("beat_wdata", bus.wdata, mon_e.wdata);
                end
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("done_expected", 32'(exp_q.size()), 32'd1);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("done_kind",  32'(mon_e.is_done), 32'd1);
                    chk("done_words", 32'(words_done), 32'(mon_e.words));
                    chk("done_err",   32'(err_timeout), 32'(mon_e.err));
                end
            end
        end
        pv   <= bus.valid;
        pr   <= bus.ready;
        prst <= reset;
        pws  <= bus.wstrb;
        pa   <= bus.addr;
        pd   <= bus.wdata;
    end

    task automatic kick(input logic [31:0] s, input logic [31:0] d, input logic si,
                        input logic di, input logic [15:0] n);
        @(negedge clk);
        cfg_src = s; cfg_dst = d; cfg_src_inc = si; cfg_dst_inc = di;
        cfg_count = n; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < limit) begin
            @(negedge clk);
            cyc++;
        end
        if (done !== 1'b1) chk("done_seen", 32'(done), 32'd1);
    endtask

    int cyc;
    int vc;

    initial begin
        #100000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(bus.valid), 32'd0);
        chk("rst_wstrb", 32'(bus.wstrb), 32'd0);
        chk("rst_addr",  bus.addr, 32'd0);
        chk("rst_wdata", bus.wdata, 32'd0);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_done",  32'(done), 32'd0);
        chk("rst_err",   32'(err_timeout), 32'd0);
        chk("rst_words", 32'(words_done), 32'd0);
        reset = 1'b0;

        // abort while idle must not stop the following transfer
        @(negedge clk); abort = 1'b1;
        @(negedge clk); abort = 1'b0;

        // RNG -> GPIO, fixed addresses, 3 words, 6 cycles each
        for (int i = 0; i < 3; i++) begin
            exp_rd(RNG_BASE);
            exp_wr(GPIO_BASE, RNG_V[i]);
        end
        exp_done(16'd3, 1'b0);
        kick(RNG_BASE, GPIO_BASE, 1'b0, 1'b0, 16'd3);
        chk("rng_busy", 32'(busy), 32'd1);
        wait_done(100, cyc);
        chk("rng_cycles", 32'(cyc), 32'd18);
        chk("rng_words", 32'(words_done), 32'd3);
        chk("rng_gpio", gpio_q, RNG_V[2]);
        chk("rng_busy_end", 32'(busy), 32'd0);

        // incrementing copy 0x100 -> 0x200
        for (int i = 0; i < 4; i++) begin
            exp_rd(32'h100 + 32'(4 * i));
            exp_wr(32'h200 + 32'(4 * i), TAB[i]);
        end
        exp_done(16'd4, 1'b0);
        kick(32'h100, 32'h200, 1'b1, 1'b1, 16'd4);
        wait_done(100, cyc);
        chk("inc_cycles", 32'(cyc), 32'd24);
        chk("inc_words", 32'(words_done), 32'd4);
        @(negedge clk);
        for (int i = 0; i < 4; i++) chk("inc_mem", mem[8'(128 + i)], TAB[i]);

        // count = 0: no beat, done one cycle after start; start in done cycle ignored
        exp_done(16'd0, 1'b0);
        kick(32'h100, 32'h200, 1'b1, 1'b1, 16'd0);
        chk("zero_valid0", 32'(bus.valid), 32'd0);
        chk("zero_busy", 32'(busy), 32'd1);
        wait_done(20, cyc);
        chk("zero_cycles", 32'(cyc), 32'd1);
        chk("zero_valid1", 32'(bus.valid), 32'd0);
        chk("zero_words", 32'(words_done), 32'd0);
        cfg_count = 16'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("done_cycle_start", 32'(busy), 32'd0);
        chk("done_cycle_valid", 32'(bus.valid), 32'd0);

        // stalled responder -> timeout after 8 valid cycles
        stall = 1'b1;
        exp_done(16'd0, 1'b1);
        kick(32'h100, 32'h200, 1'b1, 1'b1, 16'd1);
        vc = 0; cyc = 0;
        while (done !== 1'b1 && cyc < 40) begin
            if (bus.valid) vc++;
            @(negedge clk);
            cyc++;
        end
        chk("to_valid_cycles", 32'(vc), 32'd8);
        chk("to_err", 32'(err_timeout), 32'd1);
        chk("to_valid_low", 32'(bus.valid), 32'd0);
        chk("to_busy", 32'(busy), 32'd0);
        stall = 1'b0;

        // abort during read of word 2 of 5
        for (int i = 0; i < 2; i++) begin
            exp_rd(32'h100 + 32'(4 * i));
            exp_wr(32'h280 + 32'(4 * i), TAB[i]);
        end
        exp_done(16'd2, 1'b0);
        kick(32'h100, 32'h280, 1'b1, 1'b1, 16'd5);
        chk("ab_err_cleared", 32'(err_timeout), 32'd0);
        cyc = 0;
        while (!(bus.valid && bus.wstrb == 4'h0 && words_done == 16'd1) && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_done(100, cyc);
        chk("ab_words", 32'(words_done), 32'd2);
        @(negedge clk);
        chk("ab_mem1", mem[8'd161], TAB[1]);

        // second start while busy ignored; reset during write of word 2
        exp_rd(32'h100);
        exp_wr(32'h2C0, TAB[0]);
        exp_rd(32'h104);
        exp_wr(32'h2C4, TAB[1]);
        exp_done(16'd2, 1'b0);
        kick(32'h100, 32'h2C0, 1'b1, 1'b1, 16'd2);
        repeat (2) @(negedge clk);
        cfg_src = RNG_BASE; cfg_dst = GPIO_BASE; cfg_count = 16'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_start_busy", 32'(busy), 32'd1);
        cyc = 0;
        while (!(bus.valid && !bus.ready && bus.wstrb == 4'hF && words_done == 16'd1)
               && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("rst_wait_wr", 32'(bus.wstrb), 32'hF);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_valid", 32'(bus.valid), 32'd0);
        chk("midrst_busy",  32'(busy), 32'd0);
        chk("midrst_words", 32'(words_done), 32'd0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;

        // recovery: single word copy after reset
        exp_rd(32'h10C);
        exp_wr(32'h300, TAB[3]);
        exp_done(16'd1, 1'b0);
        kick(32'h10C, 32'h300, 1'b1, 1'b1, 16'd1);
        wait_done(50, cyc);
        chk("rec_cycles", 32'(cyc), 32'd6);
        @(negedge clk);
        chk("rec_mem", mem[8'd192], TAB[3]);

        repeat (3) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
